// File: rtl/div_unit_pkg.sv
// ============================================================================
// div_unit_pkg : shared types and constants for the signed divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_sign_fix.sv
// ============================================================================
// div_sign_fix : conditional two's-complement negation (abs value / result fix)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : 32-cycle restoring signed divider, quotient/remainder registered
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    input  logic             DivCtrl,
    output logic             DivDone,
    output logic             DivZero,
    output logic [WIDTH-1:0] DivHIOut,
    output logic [WIDTH-1:0] DivLOOut
);

    div_state_t       state, next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             q_neg, r_neg;

    logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fixed, r_fixed;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic             div_by_zero, last_iter;
    logic             load, trap, step, finish, clear_done;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (RegAOut),
        .negate (RegAOut[WIDTH-1]),
        .result (dvd_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (RegBOut),
        .negate (RegBOut[WIDTH-1]),
        .result (dvs_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .value  (quo),
        .negate (q_neg),
        .result (q_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .value  (rem),
        .negate (r_neg),
        .result (r_fixed)
    );

    // Trial subtract carries an extra sign bit so a borrow is never lost.
    assign shifted     = {rem, quo[WIDTH-1]};
    assign trial       = {1'b0, shifted} - {2'b00, dvs};
    assign trial_ok    = ~trial[WIDTH+1];
    assign div_by_zero = (RegBOut == '0);
    assign last_iter   = (count == CNT_W'(DIV_ITERS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        trap       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        clear_done = 1'b0;
        case (state)
            IDLE: begin
                if (DivCtrl) begin
                    load = 1'b1;
                    if (div_by_zero) begin
                        trap       = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = ITER;
                    end
                end
            end
            ITER: begin
                if (!DivCtrl) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                    if (last_iter) begin
                        next_state = FIX;
                    end
                end
            end
            FIX: begin
                if (!DivCtrl) begin
                    next_state = IDLE;
                end else begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!DivCtrl) begin
                    clear_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            count    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            DivDone  <= 1'b0;
            DivZero  <= 1'b0;
            DivHIOut <= '0;
            DivLOOut <= '0;
        end else begin
            if (load) begin
                quo     <= dvd_mag;
                dvs     <= dvs_mag;
                rem     <= '0;
                count   <= '0;
                q_neg   <= RegAOut[WIDTH-1] ^ RegBOut[WIDTH-1];
                r_neg   <= RegAOut[WIDTH-1];
                DivZero <= 1'b0;
            end
            // Zero divisor: flag completion now, leave the result registers alone.
            if (trap) begin
                DivDone <= 1'b1;
                DivZero <= 1'b1;
            end
            if (step) begin
                rem   <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo   <= {quo[WIDTH-2:0], trial_ok};
                count <= count + CNT_W'(1);
            end
            if (finish) begin
                DivLOOut <= q_fixed;
                DivHIOut <= r_fixed;
                DivDone  <= 1'b1;
                DivZero  <= 1'b0;
            end
            if (clear_done) begin
                DivDone <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed self-checking bench for div_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] RegAOut = '0;
    logic [31:0] RegBOut = '0;
    logic        DivCtrl = 1'b0;
    logic        DivDone;
    logic        DivZero;
    logic [31:0] DivHIOut;
    logic [31:0] DivLOOut;

    int total  = 0;
    int passed = 0;

    div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .RegAOut  (RegAOut),
        .RegBOut  (RegBOut),
        .DivCtrl  (DivCtrl),
        .DivDone  (DivDone),
        .DivZero  (DivZero),
        .DivHIOut (DivHIOut),
        .DivLOOut (DivLOOut)
    );

    always #5 clock = ~clock;

    // Starts an operation and counts rising edges until DivDone reads 1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int edges, output bit got_done);
        @(negedge clock);
        RegAOut  = a;
        RegBOut  = b;
        DivCtrl  = 1'b1;
        edges    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (DivDone) got_done = 1'b1;
        end
    endtask

    task automatic drop_ctrl();
        DivCtrl = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({DivDone, DivZero, DivHIOut, DivLOOut} !== 66'd0)
            $display("FAIL reset_outputs: got done=%b zero=%b hi=%h lo=%h, expected all 0",
                     DivDone, DivZero, DivHIOut, DivLOOut);
        else passed++;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int edges; bit got;
        run_op(32'd100, 32'd7, edges, got);
        total++;
        if (!got || edges != 34) $display("FAIL basic_latency: got done=%b edges=%0d, expected 1 at 34", got, edges);
        else passed++;
        total++;
        if (DivLOOut !== 32'd14 || DivHIOut !== 32'd2 || DivZero !== 1'b0)
            $display("FAIL basic_result: got lo=%h hi=%h zero=%b, expected 0000000e 00000002 0", DivLOOut, DivHIOut, DivZero);
        else passed++;
    endtask

    task automatic test_hold_release();
        repeat (3) @(negedge clock);
        total++;
        if (DivDone !== 1'b1 || DivLOOut !== 32'd14 || DivHIOut !== 32'd2)
            $display("FAIL hold_done: got done=%b lo=%h hi=%h, expected 1 0000000e 00000002", DivDone, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
        total++;
        if (DivDone !== 1'b0 || DivLOOut !== 32'd14 || DivHIOut !== 32'd2)
            $display("FAIL release_done: got done=%b lo=%h hi=%h, expected 0 0000000e 00000002", DivDone, DivLOOut, DivHIOut);
        else passed++;
    endtask

    task automatic test_signs();
        int edges; bit got;
        run_op(32'hFFFF_FFF9, 32'd2, edges, got);
        total++;
        if (!got || DivLOOut !== 32'hFFFF_FFFD || DivHIOut !== 32'hFFFF_FFFF)
            $display("FAIL neg_dividend: got done=%b lo=%h hi=%h, expected 1 fffffffd ffffffff", got, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
        run_op(32'd7, 32'hFFFF_FFFE, edges, got);
        total++;
        if (!got || DivLOOut !== 32'hFFFF_FFFD || DivHIOut !== 32'h0000_0001)
            $display("FAIL neg_divisor: got done=%b lo=%h hi=%h, expected 1 fffffffd 00000001", got, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
    endtask

    task automatic test_overflow();
        int edges; bit got;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, edges, got);
        total++;
        if (!got || DivLOOut !== 32'h8000_0000 || DivHIOut !== 32'd0 || DivZero !== 1'b0)
            $display("FAIL min_by_neg1: got done=%b lo=%h hi=%h zero=%b, expected 1 80000000 00000000 0",
                     got, DivLOOut, DivHIOut, DivZero);
        else passed++;
        drop_ctrl();
    endtask

    task automatic test_div_zero();
        int edges; bit got;
        run_op(32'd5, 32'd0, edges, got);
        total++;
        if (!got || edges != 1 || DivZero !== 1'b1)
            $display("FAIL div_zero_flag: got done=%b edges=%0d zero=%b, expected 1 1 1", got, edges, DivZero);
        else passed++;
        total++;
        if (DivLOOut !== 32'h8000_0000 || DivHIOut !== 32'd0)
            $display("FAIL div_zero_keep: got lo=%h hi=%h, expected 80000000 00000000", DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
    endtask

    task automatic test_abort();
        int edges; bit got; bit seen_done;
        @(negedge clock);
        RegAOut = 32'd100;
        RegBOut = 32'd7;
        DivCtrl = 1'b1;
        repeat (9) @(posedge clock);
        @(negedge clock);
        DivCtrl = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (DivDone) seen_done = 1'b1;
        end
        total++;
        if (seen_done) $display("FAIL abort_done: got DivDone=1 after abort, expected 0");
        else passed++;
        total++;
        if (DivLOOut !== 32'h8000_0000 || DivHIOut !== 32'd0)
            $display("FAIL abort_keep: got lo=%h hi=%h, expected 80000000 00000000", DivLOOut, DivHIOut);
        else passed++;
        run_op(32'd100, 32'd7, edges, got);
        total++;
        if (!got || edges != 34 || DivLOOut !== 32'd14 || DivHIOut !== 32'd2)
            $display("FAIL abort_restart: got done=%b edges=%0d lo=%h hi=%h, expected 1 34 0000000e 00000002",
                     got, edges, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
    endtask

    task automatic test_operand_change();
        bit got;
        @(negedge clock);
        RegAOut = 32'd20;
        RegBOut = 32'd6;
        DivCtrl = 1'b1;
        @(posedge clock);
        @(negedge clock);
        RegAOut = 32'hFFFF_FC18;
        RegBOut = 32'd13;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (DivDone) got = 1'b1;
        end
        total++;
        if (!got || DivLOOut !== 32'd3 || DivHIOut !== 32'd2)
            $display("FAIL operand_latch: got done=%b lo=%h hi=%h, expected 1 00000003 00000002", got, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
    endtask

    task automatic test_vectors();
        logic [31:0] va [10] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'h7FFF_FFFF, 32'd1,
                                 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h075B_CD15};
        logic [31:0] vb [10] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000,
                                 32'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd5, 32'd1000};
        logic [31:0] vq [10] = '{32'hFFFF_FFF2, 32'h0000_000E, 32'hFFFF_FFF2, 32'd1, 32'd0,
                                 32'hC000_0000, 32'd1, 32'd0, 32'd0, 32'h0001_E240};
        logic [31:0] vr [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd1,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h0000_0315};
        int edges; bit got;
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], edges, got);
            total++;
            if (!got || DivLOOut !== vq[i] || DivHIOut !== vr[i])
                $display("FAIL vector_%0d: got done=%b lo=%h hi=%h, expected 1 %h %h",
                         i, got, DivLOOut, DivHIOut, vq[i], vr[i]);
            else passed++;
            total++;
            if ((DivLOOut * vb[i] + DivHIOut) !== va[i] || (DivHIOut != 0 && DivHIOut[31] !== va[i][31]))
                $display("FAIL identity_%0d: got q*d+r=%h rsign=%b, expected %h sign %b",
                         i, DivLOOut * vb[i] + DivHIOut, DivHIOut[31], va[i], va[i][31]);
            else passed++;
            drop_ctrl();
        end
    endtask

    task automatic test_reset_mid();
        int edges; bit got;
        @(negedge clock);
        RegAOut = 32'd100;
        RegBOut = 32'd7;
        DivCtrl = 1'b1;
        repeat (19) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({DivDone, DivZero, DivHIOut, DivLOOut} !== 66'd0)
            $display("FAIL reset_async: got done=%b zero=%b hi=%h lo=%h, expected all 0",
                     DivDone, DivZero, DivHIOut, DivLOOut);
        else passed++;
        DivCtrl = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        total++;
        if (DivDone !== 1'b0 || DivLOOut !== 32'd0)
            $display("FAIL reset_idle: got done=%b lo=%h, expected 0 00000000", DivDone, DivLOOut);
        else passed++;
        run_op(32'd9, 32'd3, edges, got);
        total++;
        if (!got || edges != 34 || DivLOOut !== 32'd3 || DivHIOut !== 32'd0)
            $display("FAIL reset_recover: got done=%b edges=%0d lo=%h hi=%h, expected 1 34 00000003 00000000",
                     got, edges, DivLOOut, DivHIOut);
        else passed++;
        drop_ctrl();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_release();
        test_signs();
        test_overflow();
        test_div_zero();
        test_abort();
        test_operand_change();
        test_vectors();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
